// File: rtl/ser_pkg.sv
// Shared types and defaults for the bit serializer transmitter.
// Holds the state encoding and default word width used by the serializer blocks.
package ser_pkg;

    typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

    localparam int SER_DEF_WIDTH = 8;

endpackage

// File: rtl/ser_hold_reg.sv
// One-word holding register with a full flag.
// It sits between the valid/ready source and the shifter.
module ser_hold_reg
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    // load and take never coincide: the source only sees ready while the register is empty.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (take) begin
            full_d = 1'b0;
        end
        if (load) begin
            data_d = in_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data = data_q;
    assign full = full_q;

endmodule

// File: rtl/bit_serializer_tx.sv
// Parallel-to-serial transmitter that feeds a single-bit sequence detector.
// A one-word hold register lets back-to-back words stream out with no idle gap.
module bit_serializer_tx
    import ser_pkg::*;
#(
    parameter int WIDTH     = SER_DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             bit_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             word_done_q, word_done_d;

    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             hold_take;
    logic             accept;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign s_ready = !hold_full && !rst;
    assign accept  = s_valid && s_ready;

    ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .take    (hold_take),
        .in_data (s_data),
        .data    (hold_data),
        .full    (hold_full)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ser_valid_d = ser_valid_q;
        word_done_d = 1'b0;
        hold_take   = 1'b0;
        case (state_q)
            SER_IDLE: begin
                // Loading from the hold does not wait for bit_en.
                if (hold_full) begin
                    hold_take   = 1'b1;
                    shift_d     = hold_data;
                    bit_cnt_d   = '0;
                    ser_valid_d = 1'b1;
                    state_d     = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (bit_en) begin
                    if (bit_cnt_q == LAST_CNT) begin
                        word_done_d = 1'b1;
                        if (hold_full) begin
                            hold_take = 1'b1;
                            shift_d   = hold_data;
                            bit_cnt_d = '0;
                        end else begin
                            ser_valid_d = 1'b0;
                            state_d     = SER_IDLE;
                        end
                    end else begin
                        shift_d   = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                              : {1'b0, shift_q[WIDTH-1:1]};
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
        ser_out_d = ser_valid_d ? first_bit(shift_d) : IDLE_BIT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SER_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign word_done = word_done_q;
    assign busy      = (state_q == SER_SHIFT) || hold_full;

endmodule

// File: tb/tb_bit_serializer_tx.sv
// Directed self-checking bench for bit_serializer_tx.
// Covers streaming, bit_en throttling, reset mid-word and LSB-first operation.
module tb_bit_serializer_tx;

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       bit_en;
    logic       ser_out;
    logic       ser_valid;
    logic       word_done;
    logic       busy;

    logic [3:0] s_data4;
    logic       s_valid4;
    logic       s_ready4;
    logic       bit_en4;
    logic       ser_out4;
    logic       ser_valid4;
    logic       word_done4;
    logic       busy4;

    int checkCount = 0;
    int failCount  = 0;

    bit_serializer_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .bit_en    (bit_en),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .word_done (word_done),
        .busy      (busy)
    );

    bit_serializer_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data4),
        .s_valid   (s_valid4),
        .s_ready   (s_ready4),
        .bit_en    (bit_en4),
        .ser_out   (ser_out4),
        .ser_valid (ser_valid4),
        .word_done (word_done4),
        .busy      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic valid, input logic en);
        s_data  = data;
        s_valid = valid;
        bit_en  = en;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  w8;
        logic [15:0] w16;
        logic [3:0]  w4;
        logic [3:0]  hist;
        int          doneCnt;
        logic        seen;

        rst = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0);
        s_data4 = 4'h0; s_valid4 = 1'b0; bit_en4 = 1'b0;

        // Reset state
        #3;
        checkOutput("rst ser_out", 32'(ser_out), 32'd0);
        checkOutput("rst ser_valid", 32'(ser_valid), 32'd0);
        checkOutput("rst word_done", 32'(word_done), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst s_ready", 32'(s_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("post-rst s_ready", 32'(s_ready), 32'd1);

        // Test 1: single word 8'hB0, bit_en constantly 1
        $display("[TB] test 1: single word");
        w8 = 8'hB0;
        applyStimulus(w8, 1'b1, 1'b1);
        tick();
        s_valid = 1'b0;
        checkOutput("t1 s_ready after accept", 32'(s_ready), 32'd0);
        checkOutput("t1 busy after accept", 32'(busy), 32'd1);
        checkOutput("t1 ser_valid before load", 32'(ser_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput($sformatf("t1 ser_out bit%0d", i), 32'(ser_out), 32'(w8[7-i]));
            checkOutput($sformatf("t1 ser_valid bit%0d", i), 32'(ser_valid), 32'd1);
            checkOutput($sformatf("t1 word_done bit%0d", i), 32'(word_done), 32'd0);
        end
        tick();
        checkOutput("t1 word_done pulse", 32'(word_done), 32'd1);
        checkOutput("t1 ser_valid end", 32'(ser_valid), 32'd0);
        checkOutput("t1 ser_out idle", 32'(ser_out), 32'd0);
        tick();
        checkOutput("t1 word_done cleared", 32'(word_done), 32'd0);
        checkOutput("t1 busy end", 32'(busy), 32'd0);

        // Test 2: two words streamed with no gap
        $display("[TB] test 2: back-to-back words");
        w16 = 16'hB00B;
        applyStimulus(8'hB0, 1'b1, 1'b1);
        tick();
        checkOutput("t2 s_ready after accept1", 32'(s_ready), 32'd0);
        s_data = 8'h0B;
        for (int i = 0; i < 16; i++) begin
            tick();
            checkOutput($sformatf("t2 ser_out bit%0d", i), 32'(ser_out), 32'(w16[15-i]));
            checkOutput($sformatf("t2 ser_valid bit%0d", i), 32'(ser_valid), 32'd1);
            checkOutput($sformatf("t2 word_done bit%0d", i), 32'(word_done), 32'(i == 8));
            if (i == 0) checkOutput("t2 s_ready hold drained", 32'(s_ready), 32'd1);
            if (i == 1) begin
                checkOutput("t2 s_ready after accept2", 32'(s_ready), 32'd0);
                s_valid = 1'b0;
            end
        end
        tick();
        checkOutput("t2 word_done final", 32'(word_done), 32'd1);
        checkOutput("t2 ser_valid end", 32'(ser_valid), 32'd0);
        tick();

        // Test 3: bit_en every third clock
        $display("[TB] test 3: throttled bit rate");
        w8 = 8'hA5;
        applyStimulus(w8, 1'b1, 1'b0);
        tick();
        s_valid = 1'b0;
        doneCnt = 0;
        for (int k = 2; k <= 28; k++) begin
            bit_en = (k > 2) && (((k - 2) % 3) == 0);
            tick();
            if (k <= 25) begin
                checkOutput($sformatf("t3 ser_out edge%0d", k), 32'(ser_out), 32'(w8[7-((k-2)/3)]));
                checkOutput($sformatf("t3 ser_valid edge%0d", k), 32'(ser_valid), 32'd1);
            end
            if (word_done) doneCnt++;
        end
        checkOutput("t3 word_done count", 32'(doneCnt), 32'd1);
        checkOutput("t3 ser_valid end", 32'(ser_valid), 32'd0);

        // Test 4: 1011_1011 into a behavioural 1011 detector
        $display("[TB] test 4: detector feed");
        applyStimulus(8'hBB, 1'b1, 1'b1);
        tick();
        s_valid = 1'b0;
        hist = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            hist = {hist[2:0], ser_out};
            checkOutput($sformatf("t4 detect bit%0d", i + 1), 32'(hist == 4'b1011), 32'((i == 3) || (i == 7)));
        end
        tick();
        tick();

        // Test 5: reset mid-word with a second word held
        $display("[TB] test 5: reset mid-word");
        applyStimulus(8'hE1, 1'b1, 1'b1);
        tick();
        s_data = 8'h3C;
        tick();
        tick();
        s_valid = 1'b0;
        checkOutput("t5 hold full", 32'(s_ready), 32'd0);
        tick();
        checkOutput("t5 third bit", 32'(ser_out), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t5 async ser_out", 32'(ser_out), 32'd0);
        checkOutput("t5 async ser_valid", 32'(ser_valid), 32'd0);
        checkOutput("t5 async busy", 32'(busy), 32'd0);
        checkOutput("t5 async s_ready", 32'(s_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (word_done || busy || ser_valid) seen = 1'b1;
        end
        checkOutput("t5 quiet after release", 32'(seen), 32'd0);
        checkOutput("t5 s_ready after release", 32'(s_ready), 32'd1);
        checkOutput("t5 busy after release", 32'(busy), 32'd0);

        // Test 6: LSB first, WIDTH=4
        $display("[TB] test 6: LSB-first 4-bit");
        w4 = 4'b0011;
        s_data4 = w4; s_valid4 = 1'b1; bit_en4 = 1'b1;
        tick();
        s_valid4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("t6 ser_out bit%0d", i), 32'(ser_out4), 32'(w4[i]));
            checkOutput($sformatf("t6 ser_valid bit%0d", i), 32'(ser_valid4), 32'd1);
        end
        tick();
        checkOutput("t6 word_done", 32'(word_done4), 32'd1);
        checkOutput("t6 ser_valid end", 32'(ser_valid4), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
